mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Multi-master byte-bus arbiter and address decoder sitting between the system's bus masters (CPU instruction fetch, CPU load/store, HCI debug port) and the shared byte-wide RAM and HCI I/O port. It generalises the fixed two-way CPU/HCI mux to NUM_MASTERS requesters with round-robin arbitration, a priority debug master and I/O-full write stalling. Read data is routed back to the issuing master one cycle later using a registered region flag, so returned data always matches the I/O state at request time.

## Interface
Parameters:
- NUM_MASTERS, 3: number of requesting masters (2..8).
- ADDR_WIDTH, 32: master address width.
- RAM_ADDR_WIDTH, 17: RAM address width; I/O region is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11.
- DBG_MASTER, NUM_MASTERS-1: index of the priority (debug) master.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; low blocks new grants.
- req_valid  in  NUM_MASTERS  per-master request.
- req_ready  out  NUM_MASTERS  one-hot grant, same cycle as request.
- req_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wr  in  NUM_MASTERS  1 = write, 0 = read.
- req_wdata  in  NUM_MASTERS*8  packed write bytes.
- rsp_valid  out  NUM_MASTERS  one-hot read-data strobe.
- rsp_data  out  8  read byte, valid when any rsp_valid bit set.
- ram_en  out  1  RAM enable.
- ram_r_nw  out  1  1 = read, 0 = write.
- ram_a  out  RAM_ADDR_WIDTH  RAM address.
- ram_din  out  8  RAM write byte.
- ram_dout  in  8  RAM read byte, valid one cycle after read enable.
- io_en  out  1  I/O access strobe.
- io_sel  out  3  addr[2:0] of granted I/O access.
- io_wr  out  1  I/O write.
- io_din  out  8  I/O write byte.
- io_dout  in  8  I/O read byte, valid one cycle after io_en.
- io_full  in  1  I/O output buffer full.

## Operation
- Eligibility: master i eligible if req_valid[i] and not (I/O write and io_full). Ineligible masters remain pending, never dropped.
- Grant (combinational, at most one): none if rdy_in low or rst_in high; else DBG_MASTER if eligible; else first eligible index at or after rr_ptr, wrapping modulo NUM_MASTERS.
- rr_ptr: 0 at reset; on a non-debug grant to index k, rr_ptr <= (k+1) mod NUM_MASTERS; unchanged on debug grant or no grant.
- Decode of granted request: I/O region -> io_en=1, io_wr=req_wr, io_sel, io_din driven, ram_en=0. Otherwise ram_en=1, ram_r_nw=~req_wr, ram_a=addr[RAM_ADDR_WIDTH-1:0], ram_din=wdata.
- No grant: ram_en=0, io_en=0, io_wr=0, ram_r_nw=1, other outputs don't-care (drive 0).
- Reads: registers pend_valid, pend_id, pend_io at grant. Next cycle rsp_valid[pend_id]=1, rsp_data = pend_io ? io_dout : ram_dout.
- Writes: complete at grant; no response.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, ram_en=0, ram_r_nw=1, io_en=0, io_wr=0, rr_ptr=0, pend_valid=0.
- Read latency exactly 1 cycle grant->rsp_valid; throughput one access per cycle, back-to-back reads from one master allowed.
- Grant and a response in the same cycle (same or different master) are independent.
- rdy_in low: no grant; a response already pending is still delivered.
- io_full rising while I/O write pending: that master is skipped; other masters served; grant resumes first cycle io_full is low (priority/rr rules apply).
- Reset asserted while read pending: response dropped, rsp_valid=0 the following cycle.
- NUM_MASTERS=1 degenerates to pass-through with rr_ptr fixed at 0.

## Structure
- Shared package: IO_PREFIX (2'b11), region encoding, io_sel width constant.
- One sub-module: rr_arbiter (eligible mask, rr_ptr, priority index in; one-hot grant, granted index out). Decode, pending register and response mux stay in mem_bus_arbiter.

## Test plan
- Single read: master 0 reads 0x00000010, RAM returns 0xAB -> grant cycle N, rsp_valid=3'b001, rsp_data=0xAB at N+1.
- Round-robin: masters 0 and 1 request continuously from reset -> grants alternate 0,1,0,1; each master gets 2 of 4 cycles.
- Debug priority: masters 0,1,2 all request with DBG_MASTER=2 -> master 2 granted every cycle; rr_ptr unchanged; 0,1 resume in rr order when 2 drops.
- I/O stall: master 1 writes 0x41 to 0x00030000 while io_full=1 for 5 cycles -> no io_en for 5 cycles, master 0 RAM reads granted meanwhile; io_en=1, io_din=0x41 in first cycle io_full=0.
- I/O read mux: read 0x00030004 (io_dout=0x5A) followed by RAM read (ram_dout=0x33) -> rsp_data 0x5A then 0x33 on consecutive cycles, io_sel=3'b100.
- Reset mid-read: assert rst_in the cycle after a read grant -> rsp_valid stays 0, rr_ptr=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the byte-bus arbiter: I/O region prefix, region encoding and I/O select width.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] IO_PREFIX    = 2'b11;
    localparam int         IO_SEL_WIDTH = 3;

    typedef enum logic {
        REGION_RAM = 1'b0,
        REGION_IO  = 1'b1
    } region_e;

    function automatic region_e decode_region(input logic [1:0] prefix);
        return (prefix == IO_PREFIX) ? REGION_IO : REGION_RAM;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter, the shared RAM and the HCI I/O port.
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17
);
    import mem_bus_arbiter_pkg::*;

    logic [NUM_MASTERS-1:0]            req_valid;
    logic [NUM_MASTERS-1:0]            req_ready;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_MASTERS-1:0]            req_wr;
    logic [NUM_MASTERS*8-1:0]          req_wdata;
    logic [NUM_MASTERS-1:0]            rsp_valid;
    logic [7:0]                        rsp_data;

    logic                              ram_en;
    logic                              ram_r_nw;
    logic [RAM_ADDR_WIDTH-1:0]         ram_a;
    logic [7:0]                        ram_din;
    logic [7:0]                        ram_dout;

    logic                              io_en;
    logic [IO_SEL_WIDTH-1:0]           io_sel;
    logic                              io_wr;
    logic [7:0]                        io_din;
    logic [7:0]                        io_dout;
    logic                              io_full;

    // The arbiter side: takes requests and memory read data, drives grants, responses and memory strobes.
    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata, ram_dout, io_dout, io_full,
        output req_ready, rsp_valid, rsp_data,
        output ram_en, ram_r_nw, ram_a, ram_din, io_en, io_sel, io_wr, io_din
    );

    modport master (
        output req_valid, req_addr, req_wr, req_wdata, ram_dout, io_dout, io_full,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_en, ram_r_nw, ram_a, ram_din, io_en, io_sel, io_wr, io_din
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Single-grant arbiter: a fixed priority index wins outright, otherwise round-robin from the supplied pointer.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_en,
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_rr_ptr,
    input  logic [IDX_W-1:0] i_prio_idx,
    output logic [N-1:0]     o_grant,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_rr_found;

    // Scan offsets downward so the eligible master closest to the pointer is the last one written.
    always_comb begin
        w_sum      = '0;
        w_cand     = '0;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            w_sum = {1'b0, i_rr_ptr} + SUM_W'(off);
            if (w_sum >= SUM_W'(N)) begin
                w_sum = w_sum - SUM_W'(N);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_elig[w_cand]) begin
                w_rr_idx   = w_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        if (i_en) begin
            if (i_elig[i_prio_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = i_prio_idx;
            end else if (w_rr_found) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_rr_idx;
            end
            if (o_grant_valid) begin
                o_grant[o_grant_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multi-master byte-bus arbiter with RAM / HCI I/O address decode and one-cycle registered read return.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DBG_MASTER     = NUM_MASTERS - 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    mem_bus_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0]    w_is_io;
    logic [NUM_MASTERS-1:0]    w_elig;
    logic [NUM_MASTERS-1:0]    w_grant;
    logic                      w_gvalid;
    logic [IDX_W-1:0]          w_gidx;
    logic [RAM_ADDR_WIDTH-1:0] w_gram_a;
    logic [IO_SEL_WIDTH-1:0]   w_gsel;
    logic [7:0]                w_gwdata;
    logic                      w_gwr;
    logic                      w_gio;
    logic                      w_unused_addr;

    logic [IDX_W-1:0]          r_rr_ptr;
    logic                      r_pend_valid;
    logic [IDX_W-1:0]          r_pend_id;
    logic                      r_pend_io;

    // Bits above the region prefix belong to the wider system map and are not decoded here.
    assign w_unused_addr = ^bus.req_addr;

    // An I/O write facing a full output buffer waits in place rather than being dropped.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_is_io[i] = (decode_region(bus.req_addr[i*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2]) == REGION_IO);
            w_elig[i]  = bus.req_valid[i] && !(w_is_io[i] && bus.req_wr[i] && bus.io_full);
        end
    end

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_en          (rdy_in && !rst_in),
        .i_elig        (w_elig),
        .i_rr_ptr      (r_rr_ptr),
        .i_prio_idx    (IDX_W'(DBG_MASTER)),
        .o_grant       (w_grant),
        .o_grant_valid (w_gvalid),
        .o_grant_idx   (w_gidx)
    );

    always_comb begin
        w_gram_a = '0;
        w_gsel   = '0;
        w_gwdata = '0;
        w_gwr    = 1'b0;
        w_gio    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_gram_a = bus.req_addr[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
                w_gsel   = bus.req_addr[i*ADDR_WIDTH +: IO_SEL_WIDTH];
                w_gwdata = bus.req_wdata[i*8 +: 8];
                w_gwr    = bus.req_wr[i];
                w_gio    = w_is_io[i];
            end
        end
    end

    always_comb begin
        bus.req_ready = w_grant;
        bus.ram_en    = 1'b0;
        bus.ram_r_nw  = 1'b1;
        bus.ram_a     = '0;
        bus.ram_din   = '0;
        bus.io_en     = 1'b0;
        bus.io_sel    = '0;
        bus.io_wr     = 1'b0;
        bus.io_din    = '0;
        if (w_gvalid && w_gio) begin
            bus.io_en  = 1'b1;
            bus.io_wr  = w_gwr;
            bus.io_sel = w_gsel;
            bus.io_din = w_gwdata;
        end else if (w_gvalid) begin
            bus.ram_en   = 1'b1;
            bus.ram_r_nw = !w_gwr;
            bus.ram_a    = w_gram_a;
            bus.ram_din  = w_gwdata;
        end
    end

    // The debug master bypasses round-robin, so serving it leaves the pointer where it was.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rr_ptr <= '0;
        end else if (w_gvalid && (w_gidx != IDX_W'(DBG_MASTER))) begin
            r_rr_ptr <= (w_gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_gidx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
            r_pend_io    <= 1'b0;
        end else begin
            r_pend_valid <= w_gvalid && !w_gwr;
            r_pend_id    <= w_gidx;
            r_pend_io    <= w_gio;
        end
    end

    // Region is captured at grant time so the returned byte comes from the source that was addressed.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (r_pend_valid && !rst_in) begin
            bus.rsp_valid[r_pend_id] = 1'b1;
            bus.rsp_data             = r_pend_io ? bus.io_dout : bus.ram_dout;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_bus_arbiter;

    localparam int NM  = 3;
    localparam int AW  = 32;
    localparam int RAW = 17;
    localparam int DBG = NM - 1;

    typedef struct packed {
        logic [2:0]  ready;
        logic [2:0]  rspValid;
        logic [7:0]  rspData;
        logic        ramEn;
        logic        ramRnw;
        logic [16:0] ramA;
        logic [7:0]  ramDin;
        logic        ioEn;
        logic [2:0]  ioSel;
        logic        ioWr;
        logic [7:0]  ioDin;
    } out_t;

    logic clk;
    logic rst;
    logic rdy;
    int   nTests;
    int   nFail;

    mem_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW)) bus ();

    mem_bus_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .RAM_ADDR_WIDTH (RAW),
        .DBG_MASTER     (DBG)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic w, input logic [7:0] d);
        bus.req_valid[m]         = 1'b1;
        bus.req_addr[m*AW +: AW] = a;
        bus.req_wr[m]            = w;
        bus.req_wdata[m*8 +: 8]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic out_t observe();
        out_t o;
        o.ready    = bus.req_ready;
        o.rspValid = bus.rsp_valid;
        o.rspData  = bus.rsp_data;
        o.ramEn    = bus.ram_en;
        o.ramRnw   = bus.ram_r_nw;
        o.ramA     = bus.ram_a;
        o.ramDin   = bus.ram_din;
        o.ioEn     = bus.io_en;
        o.ioSel    = bus.io_sel;
        o.ioWr     = bus.io_wr;
        o.ioDin    = bus.io_din;
        return o;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        set_req(0, 32'h0000_0010, 1'b0, 8'h00);
        set_req(1, 32'h0003_0001, 1'b1, 8'h55);
        set_req(2, 32'h0000_0020, 1'b0, 8'h00);
        bus.ram_dout = 8'hFF;
        bus.io_dout  = 8'hEE;
        next_cycle();
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b000 || bus.rsp_valid !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL reset_handshake: got ready=%b rsp_valid=%b, want 000/000", bus.req_ready, bus.rsp_valid);
        end
        nTests++;
        if (bus.rsp_data !== 8'h00) begin
            nFail++;
            $display("[TB] FAIL reset_rsp_data: got %h, want 00", bus.rsp_data);
        end
        nTests++;
        if ({bus.ram_en, bus.ram_r_nw, bus.io_en, bus.io_wr} !== 4'b0100) begin
            nFail++;
            $display("[TB] FAIL reset_strobes: got ram_en,r_nw,io_en,io_wr=%b, want 0100",
                     {bus.ram_en, bus.ram_r_nw, bus.io_en, bus.io_wr});
        end
        next_cycle();
        rst = 1'b0;
        clear_reqs();
    endtask

    task automatic test_single_read();
        set_req(0, 32'h0000_0010, 1'b0, 8'h00);
        bus.ram_dout = 8'h00;
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b001 || bus.rsp_valid !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL single_read_grant: got ready=%b rsp_valid=%b, want 001/000", bus.req_ready, bus.rsp_valid);
        end
        nTests++;
        if (bus.ram_en !== 1'b1 || bus.ram_r_nw !== 1'b1 || bus.ram_a !== 17'h00010 || bus.io_en !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL single_read_ram: got en=%b r_nw=%b a=%h io_en=%b, want 1/1/00010/0",
                     bus.ram_en, bus.ram_r_nw, bus.ram_a, bus.io_en);
        end
        next_cycle();
        clear_reqs();
        bus.ram_dout = 8'hAB;
        @(negedge clk);
        nTests++;
        if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 8'hAB) begin
            nFail++;
            $display("[TB] FAIL single_read_rsp: got rsp_valid=%b data=%h, want 001/ab", bus.rsp_valid, bus.rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int cnt0;
        int cnt1;
        logic [2:0] want;
        cnt0 = 0;
        cnt1 = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_req(0, 32'h0000_0100 + 32'(c), 1'b0, 8'h00);
            set_req(1, 32'h0000_0200 + 32'(c), 1'b0, 8'h00);
            want = (c % 2 == 0) ? 3'b001 : 3'b010;
            @(negedge clk);
            if (bus.req_ready === 3'b001) cnt0++;
            if (bus.req_ready === 3'b010) cnt1++;
            nTests++;
            if (bus.req_ready !== want) begin
                nFail++;
                $display("[TB] FAIL round_robin_c%0d: got %b, want %b", c, bus.req_ready, want);
            end
            next_cycle();
        end
        nTests++;
        if (cnt0 != 2 || cnt1 != 2) begin
            nFail++;
            $display("[TB] FAIL round_robin_share: got %0d/%0d grants, want 2/2", cnt0, cnt1);
        end
        clear_reqs();
    endtask

    task automatic test_debug_priority();
        logic [2:0] want;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_req(0, 32'h0000_0300, 1'b0, 8'h00);
            set_req(1, 32'h0000_0301, 1'b0, 8'h00);
            if (c < 3) set_req(2, 32'h0000_0302, 1'b0, 8'h00);
            else bus.req_valid[2] = 1'b0;
            want = (c < 3) ? 3'b100 : ((c % 2 == 1) ? 3'b001 : 3'b010);
            @(negedge clk);
            nTests++;
            if (bus.req_ready !== want) begin
                nFail++;
                $display("[TB] FAIL debug_priority_c%0d: got %b, want %b", c, bus.req_ready, want);
            end
            next_cycle();
        end
        clear_reqs();
    endtask

    task automatic test_io_stall();
        do_reset();
        bus.io_full = 1'b1;
        set_req(1, 32'h0003_0000, 1'b1, 8'h41);
        set_req(0, 32'h0000_0020, 1'b0, 8'h00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nTests++;
            if (bus.io_en !== 1'b0 || bus.req_ready !== 3'b001 || bus.ram_en !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL io_stall_c%0d: got io_en=%b ready=%b ram_en=%b, want 0/001/1",
                         c, bus.io_en, bus.req_ready, bus.ram_en);
            end
            next_cycle();
        end
        bus.io_full = 1'b0;
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b010 || bus.io_en !== 1'b1 || bus.io_wr !== 1'b1 || bus.io_din !== 8'h41 ||
            bus.io_sel !== 3'b000 || bus.ram_en !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL io_stall_release: got ready=%b io_en=%b wr=%b din=%h sel=%b ram_en=%b, want 010/1/1/41/000/0",
                     bus.req_ready, bus.io_en, bus.io_wr, bus.io_din, bus.io_sel, bus.ram_en);
        end
        next_cycle();
        clear_reqs();
    endtask

    task automatic test_io_read_mux();
        do_reset();
        set_req(0, 32'h0003_0004, 1'b0, 8'h00);
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b001 || bus.io_en !== 1'b1 || bus.io_wr !== 1'b0 || bus.io_sel !== 3'b100 ||
            bus.ram_en !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL io_read_decode: got ready=%b io_en=%b wr=%b sel=%b ram_en=%b, want 001/1/0/100/0",
                     bus.req_ready, bus.io_en, bus.io_wr, bus.io_sel, bus.ram_en);
        end
        next_cycle();
        set_req(0, 32'h0000_0050, 1'b0, 8'h00);
        bus.io_dout  = 8'h5A;
        bus.ram_dout = 8'h11;
        @(negedge clk);
        nTests++;
        if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 8'h5A || bus.ram_en !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL io_read_rsp: got rsp_valid=%b data=%h ram_en=%b, want 001/5a/1",
                     bus.rsp_valid, bus.rsp_data, bus.ram_en);
        end
        next_cycle();
        clear_reqs();
        bus.io_dout  = 8'h77;
        bus.ram_dout = 8'h33;
        @(negedge clk);
        nTests++;
        if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 8'h33) begin
            nFail++;
            $display("[TB] FAIL ram_read_rsp: got rsp_valid=%b data=%h, want 001/33", bus.rsp_valid, bus.rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_rdy_low();
        do_reset();
        set_req(1, 32'h0000_0060, 1'b0, 8'h00);
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b010) begin
            nFail++;
            $display("[TB] FAIL rdy_low_grant: got %b, want 010", bus.req_ready);
        end
        next_cycle();
        rdy = 1'b0;
        set_req(0, 32'h0000_0061, 1'b0, 8'h00);
        bus.ram_dout = 8'hC3;
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b000 || bus.ram_en !== 1'b0 || bus.rsp_valid !== 3'b010 || bus.rsp_data !== 8'hC3) begin
            nFail++;
            $display("[TB] FAIL rdy_low_hold: got ready=%b ram_en=%b rsp_valid=%b data=%h, want 000/0/010/c3",
                     bus.req_ready, bus.ram_en, bus.rsp_valid, bus.rsp_data);
        end
        next_cycle();
        rdy = 1'b1;
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b001 || bus.rsp_valid !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL rdy_low_resume: got ready=%b rsp_valid=%b, want 001/000", bus.req_ready, bus.rsp_valid);
        end
        next_cycle();
        clear_reqs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_req(0, 32'h0000_0070, 1'b0, 8'h00);
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b001) begin
            nFail++;
            $display("[TB] FAIL reset_mid_grant: got %b, want 001", bus.req_ready);
        end
        next_cycle();
        clear_reqs();
        rst = 1'b1;
        bus.ram_dout = 8'h99;
        @(negedge clk);
        nTests++;
        if (bus.rsp_valid !== 3'b000 || bus.rsp_data !== 8'h00 || bus.req_ready !== 3'b000 ||
            {bus.ram_en, bus.ram_r_nw, bus.io_en, bus.io_wr} !== 4'b0100) begin
            nFail++;
            $display("[TB] FAIL reset_mid_outputs: got rsp_valid=%b data=%h ready=%b strobes=%b, want 000/00/000/0100",
                     bus.rsp_valid, bus.rsp_data, bus.req_ready, {bus.ram_en, bus.ram_r_nw, bus.io_en, bus.io_wr});
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        nTests++;
        if (bus.rsp_valid !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL reset_mid_after: got rsp_valid=%b, want 000", bus.rsp_valid);
        end
        next_cycle();
        set_req(0, 32'h0000_0080, 1'b0, 8'h00);
        set_req(1, 32'h0000_0081, 1'b0, 8'h00);
        @(negedge clk);
        nTests++;
        if (bus.req_ready !== 3'b001) begin
            nFail++;
            $display("[TB] FAIL reset_mid_rrptr: got %b, want 001", bus.req_ready);
        end
        next_cycle();
        clear_reqs();
    endtask

    task automatic test_random();
        logic [31:0] a [NM];
        logic        w [NM];
        logic [7:0]  d [NM];
        logic        el [NM];
        logic        io [NM];
        int          mPtr;
        int          mPendId;
        logic        mPendValid;
        logic        mPendIo;
        int          g;
        out_t        exp;
        out_t        obs;
        do_reset();
        mPtr       = 0;
        mPendId    = 0;
        mPendValid = 1'b0;
        mPendIo    = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 39) == 0);
            rdy          = ($urandom_range(0, 7) != 0);
            bus.io_full  = ($urandom_range(0, 2) == 0);
            bus.ram_dout = 8'($urandom);
            bus.io_dout  = 8'($urandom);
            for (int m = 0; m < NM; m++) begin
                a[m] = $urandom;
                if ($urandom_range(0, 1) == 1) a[m][17:16] = 2'b11;
                else a[m][17:16] = 2'($urandom_range(0, 2));
                w[m]  = 1'($urandom_range(0, 1));
                d[m]  = 8'($urandom);
                io[m] = (a[m][17:16] == 2'b11);
                bus.req_valid[m]         = ($urandom_range(0, 3) != 0);
                bus.req_addr[m*AW +: AW] = a[m];
                bus.req_wr[m]            = w[m];
                bus.req_wdata[m*8 +: 8]  = d[m];
                el[m] = bus.req_valid[m] && !(io[m] && w[m] && bus.io_full);
            end
            g = -1;
            if (rdy && !rst) begin
                if (el[DBG]) g = DBG;
                else begin
                    for (int k = 0; k < NM; k++) begin
                        if (g < 0 && el[(mPtr + k) % NM]) g = (mPtr + k) % NM;
                    end
                end
            end
            exp        = '0;
            exp.ramRnw = 1'b1;
            if (g >= 0) begin
                exp.ready = 3'(1 << g);
                if (io[g]) begin
                    exp.ioEn  = 1'b1;
                    exp.ioWr  = w[g];
                    exp.ioSel = a[g][2:0];
                    exp.ioDin = d[g];
                end else begin
                    exp.ramEn  = 1'b1;
                    exp.ramRnw = !w[g];
                    exp.ramA   = a[g][16:0];
                    exp.ramDin = d[g];
                end
            end
            if (mPendValid && !rst) begin
                exp.rspValid = 3'(1 << mPendId);
                exp.rspData  = mPendIo ? bus.io_dout : bus.ram_dout;
            end
            @(negedge clk);
            obs = observe();
            if (!exp.ramEn) begin
                obs.ramA   = '0;
                obs.ramDin = '0;
            end
            if (!exp.ioEn) begin
                obs.ioSel = '0;
                obs.ioDin = '0;
            end
            if (exp.ioEn) obs.ramRnw = exp.ramRnw;
            if (exp.ramEn) obs.ioWr = exp.ioWr;
            nTests++;
            if (obs !== exp) begin
                nFail++;
                $display("[TB] FAIL random_c%0d: got %h, want %h", c, obs, exp);
            end
            if (rst) begin
                mPtr       = 0;
                mPendValid = 1'b0;
            end else begin
                mPendValid = 1'b0;
                if (g >= 0) begin
                    mPendValid = !w[g];
                    mPendId    = g;
                    mPendIo    = io[g];
                    if (g != DBG) mPtr = (g + 1) % NM;
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        rdy = 1'b1;
        bus.io_full = 1'b0;
        clear_reqs();
    endtask

    initial begin
        nTests       = 0;
        nFail        = 0;
        rst          = 1'b1;
        rdy          = 1'b1;
        bus.io_full  = 1'b0;
        bus.ram_dout = 8'h00;
        bus.io_dout  = 8'h00;
        clear_reqs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_debug_priority();
        test_io_stall();
        test_io_read_mux();
        test_rdy_low();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
